// File: rtl/wade_uio_if.sv
// wade_uio_if: requester/pad-side bundle of the uio bus arbiter.
//   req    [NREQ]   per-requester burst request (level)
//   dir    [NREQ]   per-requester direction, 1 = write, 0 = read
//   wdata  [8*NREQ] write data, requester i on [8i+7:8i]
//   uio_in [8]      pad input path
//   gnt    [NREQ]   one-hot registered grant
//   uio_out/uio_oe  pad output data / enable
//   rdata/rvalid/rid registered read data, valid pulse, owner index
// modport master: requesters and pads; modport slave: the arbiter.
interface wade_uio_if #(
  parameter int NREQ = 3
) ();
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   dir;
  logic [8*NREQ-1:0] wdata;
  logic [7:0]        uio_in;
  logic [NREQ-1:0]   gnt;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;
  logic [7:0]        rdata;
  logic              rvalid;
  logic [1:0]        rid;

  modport master (
    output req, dir, wdata, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid, rid
  );

  modport slave (
    input  req, dir, wdata, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid, rid
  );
endinterface

// File: rtl/wade_uio_arbiter.sv
// wade_uio_arbiter: round-robin burst arbiter sharing the 8-bit uio pad bus.
// Idle turnaround cycles are inserted whenever the bus direction flips so
// the pads and the external device never drive at the same time.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   ena    design enable; low forces the arbiter idle
//   bus    wade_uio_if.slave (requests, write data, pads, grants, read data)
module wade_uio_arbiter #(
  parameter int NREQ      = 3,
  parameter int TURN      = 1,
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  wade_uio_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_XFER} state_t;

  localparam logic [1:0] TURN_LAST = (TURN > 0) ? 2'(TURN - 1) : 2'd0;
  localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);
  localparam logic [3:0] BEAT_MAX  = 4'(MAX_BURST);

  state_t          state_q, state_d;
  logic [1:0]      w_q;
  logic            wdir_q;
  logic            bus_dir_q;
  logic [1:0]      tcnt_q;
  logic [3:0]      bcnt_q;
  logic [1:0]      rr_q;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q;
  logic            rvalid_q;
  logic [1:0]      rid_q;

  logic [1:0]      win;
  logic            win_dir;
  logic            win_found;
  logic            req_w;
  logic [7:0]      wdata_w;
  logic [1:0]      next_w;
  logic            beat;

  // Round-robin scan starting just above the last owner, plus the
  // request/data lines of the currently latched owner.
  always_comb begin
    win       = rr_q;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(rr_q) + k) % NREQ;
      if (!win_found && bus.req[j]) begin
        win_found = 1'b1;
        win       = 2'(j);
      end
    end
    win_dir = 1'b0;
    req_w   = 1'b0;
    wdata_w = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 2'(i)) win_dir = bus.dir[i];
      if (w_q == 2'(i)) begin
        req_w   = bus.req[i];
        wdata_w = bus.wdata[8*i +: 8];
      end
    end
  end

  // A beat needs the grant (implied by XFER) and a live request.
  assign beat   = (state_q == S_XFER) && ena && req_w;
  assign next_w = (state_q == S_IDLE) ? win : w_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          if ((win_dir != bus_dir_q) && (TURN > 0)) state_d = S_TURN;
          else                                      state_d = S_XFER;
        end
      end
      S_TURN: begin
        if (tcnt_q == TURN_LAST) state_d = S_XFER;
      end
      S_XFER: begin
        // Dropped request or count-limited final beat both exit here.
        if (!req_w || (bcnt_q == BEAT_LAST)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!ena) state_d = S_IDLE;

    // Grant is registered: computed for the state being entered.
    gnt_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_d[i] = (state_d == S_XFER) && (next_w == 2'(i));
    end
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      w_q       <= 2'd0;
      wdir_q    <= 1'b0;
      bus_dir_q <= 1'b0;
      tcnt_q    <= 2'd0;
      bcnt_q    <= 4'd0;
      rr_q      <= 2'(NREQ - 1);
      gnt_q     <= '0;
      rdata_q   <= 8'h00;
      rvalid_q  <= 1'b0;
      rid_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;

      if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
        w_q    <= win;
        wdir_q <= win_dir;
      end

      // Bus direction only ever changes on entry to a transfer, after any
      // turnaround has elapsed; with TURN=0 it switches immediately.
      if ((state_d == S_XFER) && (state_q != S_XFER)) begin
        bus_dir_q <= (state_q == S_IDLE) ? win_dir : wdir_q;
      end

      tcnt_q <= ((state_q == S_TURN) && (state_d == S_TURN)) ? tcnt_q + 2'd1 : 2'd0;

      if (state_q != S_XFER)                bcnt_q <= 4'd0;
      else if (beat && (bcnt_q != BEAT_MAX)) bcnt_q <= bcnt_q + 4'd1;

      // Only a genuine burst exit advances the pointer; an ena drop does not.
      if ((state_q == S_XFER) && ena && (state_d == S_IDLE)) rr_q <= w_q;

      rvalid_q <= beat && !bus_dir_q;
      if (beat && !bus_dir_q) begin
        rdata_q <= bus.uio_in;
        rid_q   <= w_q;
      end
    end
  end

  // Output logic: pads driven only during a write transfer.
  always_comb begin
    bus.uio_oe  = 8'h00;
    bus.uio_out = 8'h00;
    if ((state_q == S_XFER) && bus_dir_q) begin
      bus.uio_oe  = 8'hFF;
      bus.uio_out = wdata_w;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rid    = rid_q;

endmodule

// File: tb/tb_wade_uio_arbiter.sv
module tb_wade_uio_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   n_chk = 0;
  int   n_err = 0;

  wade_uio_if #(.NREQ(3)) bus ();

  wade_uio_arbiter #(.NREQ(3), .TURN(1), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b0;
    bus.req = '0;
    bus.dir = '0;
    bus.wdata = '0;
    bus.uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_oe", 32'(bus.uio_oe), 0);
    chk("rst_out", 32'(bus.uio_out), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rid", 32'(bus.rid), 0);
    rst_n = 1'b1;
  endtask

  logic [2:0] rr_gnt [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [1:0] rr_id  [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  logic [2:0] cap_gnt [13] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                               3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                               3'b100, 3'b100, 3'b100};

  initial begin
    // Single write with turnaround
    do_reset();
    ena = 1'b1;
    bus.req = 3'b001;
    bus.dir = 3'b001;
    bus.wdata = 24'h0000A5;
    #1;
    chk("w1_idle_gnt", 32'(bus.gnt), 0);
    step();
    chk("w1_turn_gnt", 32'(bus.gnt), 0);
    chk("w1_turn_oe", 32'(bus.uio_oe), 0);
    chk("w1_turn_out", 32'(bus.uio_out), 0);
    step();
    chk("w1_x0_gnt", 32'(bus.gnt), 32'h1);
    chk("w1_x0_oe", 32'(bus.uio_oe), 32'hFF);
    chk("w1_x0_out", 32'(bus.uio_out), 32'hA5);
    step();
    chk("w1_x1_gnt", 32'(bus.gnt), 32'h1);
    chk("w1_x1_out", 32'(bus.uio_out), 32'hA5);
    step();
    chk("w1_x2_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 3'b000;
    step();
    chk("w1_end_gnt", 32'(bus.gnt), 0);
    chk("w1_end_oe", 32'(bus.uio_oe), 0);
    chk("w1_end_out", 32'(bus.uio_out), 0);

    // Round robin, all reads, bursts capped at 4
    do_reset();
    ena = 1'b1;
    bus.req = 3'b111;
    bus.dir = 3'b000;
    for (int g = 0; g < 4; g++) begin
      bus.uio_in = 8'h40 + 8'(g);
      step();
      chk($sformatf("rr%0d_first", g), 32'(bus.gnt), 32'(rr_gnt[g]));
      chk($sformatf("rr%0d_oe", g), 32'(bus.uio_oe), 0);
      for (int c = 0; c < 3; c++) begin
        step();
        chk($sformatf("rr%0d_hold%0d", g, c), 32'(bus.gnt), 32'(rr_gnt[g]));
        chk($sformatf("rr%0d_rv%0d", g, c), 32'(bus.rvalid), 1);
      end
      step();
      chk($sformatf("rr%0d_gap", g), 32'(bus.gnt), 0);
      chk($sformatf("rr%0d_rvalid", g), 32'(bus.rvalid), 1);
      chk($sformatf("rr%0d_rid", g), 32'(bus.rid), 32'(rr_id[g]));
      chk($sformatf("rr%0d_rdata", g), 32'(bus.rdata), 32'h40 + g);
    end
    bus.req = 3'b000;
    step();
    chk("rr_quiet_gnt", 32'(bus.gnt), 0);
    chk("rr_quiet_rv", 32'(bus.rvalid), 0);

    // Read by requester 0, then write by requester 1 across a turnaround
    bus.req = 3'b001;
    bus.dir = 3'b000;
    bus.uio_in = 8'h3C;
    step();
    chk("dc_rd_gnt", 32'(bus.gnt), 32'h1);
    chk("dc_rd_oe", 32'(bus.uio_oe), 0);
    step();
    chk("dc_rvalid", 32'(bus.rvalid), 1);
    chk("dc_rdata", 32'(bus.rdata), 32'h3C);
    chk("dc_rid", 32'(bus.rid), 0);
    chk("dc_beat_oe", 32'(bus.uio_oe), 0);
    bus.req = 3'b010;
    bus.dir = 3'b010;
    bus.wdata = 24'h005A00;
    step();
    chk("dc_idle_gnt", 32'(bus.gnt), 0);
    chk("dc_idle_oe", 32'(bus.uio_oe), 0);
    chk("dc_idle_rv", 32'(bus.rvalid), 0);
    step();
    chk("dc_turn_gnt", 32'(bus.gnt), 0);
    chk("dc_turn_oe", 32'(bus.uio_oe), 0);
    step();
    chk("dc_wr_gnt", 32'(bus.gnt), 32'h2);
    chk("dc_wr_oe", 32'(bus.uio_oe), 32'hFF);
    chk("dc_wr_out", 32'(bus.uio_out), 32'h5A);
    step();
    chk("dc_wr_hold", 32'(bus.gnt), 32'h2);
    bus.req = 3'b000;
    step();
    chk("dc_end_gnt", 32'(bus.gnt), 0);

    // Burst cap: requester 2 writes 10 beats as 4 + 4 + 2
    bus.req = 3'b100;
    bus.dir = 3'b100;
    bus.wdata = 24'hC30000;
    for (int s = 0; s < 13; s++) begin
      step();
      chk($sformatf("cap_s%0d_gnt", s), 32'(bus.gnt), 32'(cap_gnt[s]));
      chk($sformatf("cap_s%0d_oe", s), 32'(bus.uio_oe), (cap_gnt[s] != 0) ? 32'hFF : 32'h0);
      chk($sformatf("cap_s%0d_out", s), 32'(bus.uio_out), (cap_gnt[s] != 0) ? 32'hC3 : 32'h0);
    end
    bus.req = 3'b000;
    step();
    chk("cap_end_gnt", 32'(bus.gnt), 0);

    // ena drop during the third write beat
    bus.req = 3'b001;
    bus.dir = 3'b001;
    bus.wdata = 24'h000011;
    step();
    chk("en_x0_gnt", 32'(bus.gnt), 32'h1);
    chk("en_x0_oe", 32'(bus.uio_oe), 32'hFF);
    step();
    step();
    chk("en_x2_gnt", 32'(bus.gnt), 32'h1);
    ena = 1'b0;
    step();
    chk("en_off_gnt", 32'(bus.gnt), 0);
    chk("en_off_oe", 32'(bus.uio_oe), 0);
    chk("en_off_out", 32'(bus.uio_out), 0);
    ena = 1'b1;
    step();
    chk("en_re_gnt", 32'(bus.gnt), 32'h1);
    chk("en_re_oe", 32'(bus.uio_oe), 32'hFF);
    bus.req = 3'b000;
    step();
    chk("en_end_gnt", 32'(bus.gnt), 0);

    // Asynchronous reset in the middle of a write burst
    bus.req = 3'b010;
    bus.dir = 3'b010;
    bus.wdata = 24'h007700;
    step();
    chk("ar_x0_gnt", 32'(bus.gnt), 32'h2);
    chk("ar_x0_oe", 32'(bus.uio_oe), 32'hFF);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", 32'(bus.gnt), 0);
    chk("ar_oe", 32'(bus.uio_oe), 0);
    chk("ar_out", 32'(bus.uio_out), 0);
    chk("ar_rvalid", 32'(bus.rvalid), 0);
    rst_n = 1'b1;
    bus.req = 3'b011;
    bus.dir = 3'b000;
    step();
    chk("ar_prio_gnt", 32'(bus.gnt), 32'h1);
    chk("ar_prio_oe", 32'(bus.uio_oe), 0);
    bus.req = 3'b000;
    step();
    chk("ar_end_gnt", 32'(bus.gnt), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wade_uio_arbiter.md
Name: wade_uio_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 8-bit bidirectional uio pad bus of the tt_um_wade top level between NREQ internal requesters.
- Each requester is granted a burst of read or write beats, up to MAX_BURST beats long.
- Drives uio_out/uio_oe directly.
- Inserts bus-turnaround idle cycles whenever the bus direction changes, so that pads and the external device never drive the bus at the same time.

Parameters:
- NREQ, 3, number of requesters (2..4).
- TURN, 1, turnaround cycles on a direction change (0..3; 0 means no turnaround).
- MAX_BURST, 4, maximum beats per grant (1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design enable; low forces the arbiter idle.
- req  input  NREQ  per-requester request, level, held for the whole burst.
- dir  input  NREQ  per-requester direction: 1 = write (drive pads), 0 = read (sample pads).
- wdata  input  8*NREQ  write data; requester i uses bits [8i+7:8i].
- uio_in  input  8  pad input path.
- gnt  output  NREQ  one-hot grant, registered.
- uio_out  output  8  pad output data.
- uio_oe  output  8  pad output enable (8'hFF or 8'h00 only).
- rdata  output  8  registered read data.
- rvalid  output  1  rdata valid, one-cycle pulse.
- rid  output  2  index of the requester that owns rdata.

Behaviour:
Reset (asynchronous, rst_n low):
- gnt=0, uio_oe=0, uio_out=0, rdata=0, rvalid=0, rid=0.
- state=IDLE, rr pointer=NREQ-1 (requester 0 therefore has first priority), bus_dir=0 (read), beat count=0.
- Reset asserted mid-burst aborts the burst immediately; no further beats.

State IDLE:
- Outputs: gnt=0, uio_oe=0.
- If ena=1 and req!=0: winner w = first set req bit scanning upward from rr+1, wrapping modulo NREQ. Latch w and dir[w].
- If dir[w]!=bus_dir and TURN>0: go to TURN. Otherwise go to XFER.

State TURN:
- Outputs: gnt=0, uio_oe=0.
- Stays exactly TURN cycles, then sets bus_dir=dir[w] and goes to XFER.
- Requests are not re-sampled here; w is fixed.

State XFER:
- gnt[w]=1 on the first XFER cycle, one cycle after the decision.
- uio_oe = 8'hFF if bus_dir=1, else 8'h00.
- uio_out = wdata[w] combinationally from the latched w; it is 0 whenever the bus is not in a write XFER.
- A beat completes on every rising edge where gnt[w]=1 and req[w]=1.
- Read beat: rdata<=uio_in, rid<=w, and rvalid pulses high for the cycle after the beat.
- Burst exit, taken on the same edge, into IDLE with rr<=w and gnt cleared:
  - req[w] sampled low at an edge (no beat on that edge), or
  - the beat count reaches MAX_BURST.
- A requester must drop req[w] or supply its next wdata by the edge after each beat.
- dir[w] changing mid-burst is ignored; the latched direction holds until IDLE.

ena behaviour:
- ena=0 in any state forces IDLE on the next edge and clears gnt and uio_oe.
- bus_dir is retained; rvalid from an already-completed beat still pulses.

Rearbitration:
- Minimum gap between grants is one IDLE cycle, plus TURN cycles on a direction change.
- Same direction: IDLE→XFER directly, so the bus is idle for 1 cycle.

Simultaneous events:
- Beat count reaching MAX_BURST on the same edge req drops: exit once; the count-limited beat counts.
- A requester asserting req during another's burst waits; it is not preempted.

Widths:
- Beat counter is 4 bits and saturates at MAX_BURST.
- rr and rid are 2 bits; unused high index values never occur.

Test Plan:
1. Single write: reset, ena=1, req=3'b001, dir=3'b001, wdata[7:0]=8'hA5 held 2 cycles.
   - TURN=1 cycle with oe=0, then gnt=001 and uio_oe=FF.
   - uio_out=A5 for 2 beats, then IDLE with gnt=0 and oe=0.
2. Round robin: req=3'b111 all reads held, MAX_BURST=4.
   - Grants in order 001, 010, 100, 001, each exactly 4 cycles, separated by 1 IDLE cycle.
   - No TURN cycles, since bus_dir stays 0.
3. Direction change: requester 0 reads (uio_in=8'h3C), then requester 1 writes 8'h5A.
   - rvalid=1, rdata=3C, rid=0 one cycle after the read beat.
   - Then IDLE, TURN (oe=0), then oe=FF with uio_out=5A; oe is never FF in the same cycle as a read beat.
4. Burst cap: requester 2 holds req for 10 cycles.
   - Granted 4 beats, released for 1 IDLE cycle, re-granted 4, then 2.
5. ena drop mid-burst: ena=0 during the third write beat.
   - Next edge: gnt=0, oe=0, state IDLE. After ena=1, rearbitration with no TURN, since bus_dir is still write.
6. Async reset mid-XFER: pulse rst_n low between clock edges.
   - gnt, uio_oe and rvalid go to 0 immediately, without waiting for a clock edge.
   - After release, requester 0 has first priority.
